// File: rtl/t5_sched_pkg.sv
// Shared types and the t5 logic function for the t5 evaluation scheduler.
// Stage tags are carried at a fixed maximum width and narrowed at the top level.
package t5_sched_pkg;

  localparam int T5_TAG_MAX_W = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic                    valid;
    logic [T5_TAG_MAX_W-1:0] tag;
    logic [1:0]              po;
  } stage_t;

  // Returns {po1, po0} for the operand vector {pi4,pi3,pi2,pi1,pi0}.
  function automatic logic [1:0] t5_eval(input logic [4:0] pi);
    logic po0;
    logic po1;
    po0 = (pi[0] & pi[2]) | (pi[1] & ~(pi[2] & pi[3]));
    po1 = ~(pi[2] & pi[3]) & (pi[1] | pi[4]);
    return {po1, po0};
  endfunction

endpackage

// File: rtl/t5_sched_pipe.sv
// Stall-able shift register of evaluated results; every stage freezes together on stall.
// Occupancy is the live count of valid stages.
module t5_sched_pipe
  import t5_sched_pkg::*;
#(
  parameter int PIPE_STAGES = 4,
  parameter int OCC_W       = $clog2(PIPE_STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_stall,
  input  stage_t           i_stage,
  output stage_t           o_stage,
  output logic [OCC_W-1:0] o_occupancy
);

  stage_t           r_stage [PIPE_STAGES];
  logic [OCC_W-1:0] w_occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        r_stage[k] <= '0;
      end
    end else if (!i_stall) begin
      r_stage[0] <= i_stage;
      for (int k = 1; k < PIPE_STAGES; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int k = 0; k < PIPE_STAGES; k++) begin
      w_occ = w_occ + OCC_W'(r_stage[k].valid);
    end
  end

  assign o_stage     = r_stage[PIPE_STAGES-1];
  assign o_occupancy = w_occ;

endmodule

// File: rtl/t5_eval_scheduler.sv
// Round-robin scheduler sharing one pipelined t5 evaluator between NREQ requesters,
// with a flush/drain sequencer that pulses flush_done once the pipeline is empty.
module t5_eval_scheduler
  import t5_sched_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int PIPE_STAGES = 4,
  parameter int TAG_W       = $clog2(NREQ),
  parameter int OCC_W       = $clog2(PIPE_STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*5-1:0] req_vec,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [1:0]        rsp_po,
  input  logic              rsp_ready,
  input  logic              flush_req,
  output logic              flush_done,
  output logic [OCC_W-1:0]  occupancy
);

  logic [4:0]       w_vec [NREQ];
  logic [TAG_W-1:0] r_rr_ptr;
  logic [TAG_W-1:0] w_cand;
  logic [TAG_W-1:0] w_gnt_idx;
  logic             w_found;
  logic             w_stall;
  logic             w_grant_en;
  logic             w_accept;
  stage_t           w_load;
  stage_t           w_tail;
  sched_state_t     r_state;
  sched_state_t     w_state_next;
  logic             r_hold;
  logic             w_hold_next;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_vec[gi] = req_vec[5*gi +: 5];
    end
  endgenerate

  assign w_stall    = w_tail.valid & ~rsp_ready;
  assign w_grant_en = rst_n & ~w_stall & (r_state == RUN);
  assign w_accept   = w_grant_en & w_found;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = TAG_W'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  assign req_ready = w_accept ? (NREQ'(1) << w_gnt_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (w_gnt_idx == TAG_W'(NREQ - 1)) ? '0 : w_gnt_idx + TAG_W'(1);
    end
  end

  // Idle slots enter the pipe as all-zero so empty outputs read back as zero.
  always_comb begin
    w_load = '0;
    if (w_accept) begin
      w_load.valid = 1'b1;
      w_load.tag   = T5_TAG_MAX_W'(w_gnt_idx);
      w_load.po    = t5_eval(w_vec[w_gnt_idx]);
    end
  end

  t5_sched_pipe #(
    .PIPE_STAGES(PIPE_STAGES),
    .OCC_W      (OCC_W)
  ) u_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_stall    (w_stall),
    .i_stage    (w_load),
    .o_stage    (w_tail),
    .o_occupancy(occupancy)
  );

  assign rsp_valid = w_tail.valid;
  assign rsp_tag   = TAG_W'(w_tail.tag);
  assign rsp_po    = w_tail.po;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_hold  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_hold  <= w_hold_next;
    end
  end

  // r_hold parks the FSM in DRAIN after a pulse until flush_req drops, preventing a re-pulse.
  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold;
    case (r_state)
      RUN: begin
        if (flush_req) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (r_hold) begin
          if (!flush_req) begin
            w_state_next = RUN;
            w_hold_next  = 1'b0;
          end
        end else if (occupancy == '0) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (flush_req) begin
          w_state_next = DRAIN;
          w_hold_next  = 1'b1;
        end else begin
          w_state_next = RUN;
        end
      end
      default: begin
        w_state_next = RUN;
        w_hold_next  = 1'b0;
      end
    endcase
  end

  always_comb begin
    flush_done = (r_state == DONE);
  end

endmodule
